vga_timing_core: RTL and testbench

VGA_TIMING_CORE -- requirements
Module: vga_timing_core

---
 rtl/vga_timing_core.sv | 148 ++++++++++++++
 tb/tb_vga_timing_core.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_core.sv
// rtl/vga_timing_core.sv - VGA raster timing: pixel divider, x/y counters, delayed sync/blank
// Sync and blank are decoded from x/y and then delayed PIPE pixel ticks to line up with pixel data.
module vga_timing_core #(
    parameter int HACTIVE = 640,
    parameter int HFP     = 16,
    parameter int HSYN    = 96,
    parameter int HBP     = 48,
    parameter int VACTIVE = 480,
    parameter int VFP     = 10,
    parameter int VSYN    = 2,
    parameter int VBP     = 33,
    parameter bit HPOL    = 1'b0,
    parameter bit VPOL    = 1'b0,
    parameter int CLK_DIV = 2,
    parameter int PIPE    = 2,
    parameter int CW      = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          pix_ce,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          req_active,
    output logic          hsync,
    output logic          vsync,
    output logic          blank_n,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    localparam int HTOTAL = HACTIVE + HFP + HSYN + HBP;
    localparam int VTOTAL = VACTIVE + VFP + VSYN + VBP;

    // Inclusive bounds so no constant ever needs to hold HTOTAL/VTOTAL itself.
    localparam logic [CW-1:0] H_LAST   = CW'(HTOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(VTOTAL - 1);
    localparam logic [CW-1:0] HA_LAST  = CW'(HACTIVE - 1);
    localparam logic [CW-1:0] VA_LAST  = CW'(VACTIVE - 1);
    localparam logic [CW-1:0] HS_FIRST = CW'(HACTIVE + HFP);
    localparam logic [CW-1:0] HS_LAST  = CW'(HACTIVE + HFP + HSYN - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(VACTIVE + VFP);
    localparam logic [CW-1:0] VS_LAST  = CW'(VACTIVE + VFP + VSYN - 1);
    localparam logic [2:0]    DIV_LAST = 3'(CLK_DIV - 1);

    logic            run_q, run_d;
    logic [2:0]      div_q, div_d;
    logic [CW-1:0]   x_q, x_d;
    logic [CW-1:0]   y_q, y_d;
    logic [7:0]      fcnt_q, fcnt_d;
    logic [PIPE-1:0] hs_q, hs_d;
    logic [PIPE-1:0] vs_q, vs_d;
    logic [PIPE-1:0] bn_q, bn_d;

    logic            tick;
    logic            x_wrap;
    logic            y_wrap;
    logic            act_raw;
    logic            hs_raw;
    logic            vs_raw;
    logic [PIPE:0]   hs_ext;
    logic [PIPE:0]   vs_ext;
    logic [PIPE:0]   bn_ext;

    // run_q marks that the previous edge was enabled; the divider only counts from then on.
    assign tick    = run_q && (div_q == DIV_LAST);
    assign x_wrap  = (x_q == H_LAST);
    assign y_wrap  = (y_q == V_LAST);
    assign act_raw = (x_q <= HA_LAST) && (y_q <= VA_LAST);
    assign hs_raw  = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
    assign vs_raw  = (y_q >= VS_FIRST) && (y_q <= VS_LAST);

    assign hs_ext = {hs_q, hs_raw};
    assign vs_ext = {vs_q, vs_raw};
    assign bn_ext = {bn_q, act_raw};

    always_comb begin
        run_d  = en;
        div_d  = '0;
        x_d    = x_q;
        y_d    = y_q;
        fcnt_d = fcnt_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        bn_d   = bn_q;
        if (!en) begin
            x_d  = '0;
            y_d  = '0;
            hs_d = '0;
            vs_d = '0;
            bn_d = '0;
        end else if (run_q) begin
            if (!tick) begin
                div_d = div_q + 3'd1;
            end else begin
                hs_d = hs_ext[PIPE-1:0];
                vs_d = vs_ext[PIPE-1:0];
                bn_d = bn_ext[PIPE-1:0];
                if (x_wrap) begin
                    x_d = '0;
                    if (y_wrap) begin
                        y_d    = '0;
                        fcnt_d = fcnt_q + 8'd1;
                    end else begin
                        y_d = y_q + CW'(1);
                    end
                end else begin
                    x_d = x_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q  <= 1'b0;
            div_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            fcnt_q <= '0;
            hs_q   <= '0;
            vs_q   <= '0;
            bn_q   <= '0;
        end else begin
            run_q  <= run_d;
            div_q  <= div_d;
            x_q    <= x_d;
            y_q    <= y_d;
            fcnt_q <= fcnt_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            bn_q   <= bn_d;
        end
    end

    assign pix_ce      = tick;
    assign x           = x_q;
    assign y           = y_q;
    assign req_active  = act_raw;
    assign hsync       = hs_q[PIPE-1] ? HPOL : ~HPOL;
    assign vsync       = vs_q[PIPE-1] ? VPOL : ~VPOL;
    assign blank_n     = bn_q[PIPE-1];
    assign line_start  = tick && (x_q == '0);
    assign frame_start = tick && (x_q == '0) && (y_q == '0);
    assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_timing_core.sv
// tb/tb_vga_timing_core.sv - three-configuration bench with tick-count reference model
module tb_vga_timing_core;

    // Instance 0: default VGA, 1: tiny CLK_DIV=1/PIPE=1, 2: mid-size CLK_DIV=8/PIPE=3.
    localparam int C_HA[3]   = '{640, 4, 20};
    localparam int C_HFP[3]  = '{16, 1, 3};
    localparam int C_HSY[3]  = '{96, 1, 5};
    localparam int C_HBP[3]  = '{48, 1, 4};
    localparam int C_VA[3]   = '{480, 2, 10};
    localparam int C_VFP[3]  = '{10, 1, 2};
    localparam int C_VSY[3]  = '{2, 1, 3};
    localparam int C_VBP[3]  = '{33, 1, 2};
    localparam int C_DIV[3]  = '{2, 1, 8};
    localparam int C_PIPE[3] = '{2, 1, 3};
    localparam int C_HPOL[3] = '{0, 1, 1};
    localparam int C_VPOL[3] = '{0, 1, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    logic [2:0]       pce_w, ra_w, hs_w, vs_w, bn_w, ls_w, fs_w;
    logic [2:0][9:0]  x_w, y_w;
    logic [2:0][7:0]  fc_w;

    int n_checks = 0;
    int n_errors = 0;
    int e_m[3];
    int fc_m[3];

    always #5 clk = ~clk;

    vga_timing_core u_def (
        .clk(clk), .rst(rst), .en(en), .pix_ce(pce_w[0]), .x(x_w[0]), .y(y_w[0]),
        .req_active(ra_w[0]), .hsync(hs_w[0]), .vsync(vs_w[0]), .blank_n(bn_w[0]),
        .line_start(ls_w[0]), .frame_start(fs_w[0]), .frame_cnt(fc_w[0])
    );

    vga_timing_core #(
        .HACTIVE(4), .HFP(1), .HSYN(1), .HBP(1), .VACTIVE(2), .VFP(1), .VSYN(1), .VBP(1),
        .HPOL(1'b1), .VPOL(1'b1), .CLK_DIV(1), .PIPE(1), .CW(10)
    ) u_sml (
        .clk(clk), .rst(rst), .en(en), .pix_ce(pce_w[1]), .x(x_w[1]), .y(y_w[1]),
        .req_active(ra_w[1]), .hsync(hs_w[1]), .vsync(vs_w[1]), .blank_n(bn_w[1]),
        .line_start(ls_w[1]), .frame_start(fs_w[1]), .frame_cnt(fc_w[1])
    );

    vga_timing_core #(
        .HACTIVE(20), .HFP(3), .HSYN(5), .HBP(4), .VACTIVE(10), .VFP(2), .VSYN(3), .VBP(2),
        .HPOL(1'b1), .VPOL(1'b0), .CLK_DIV(8), .PIPE(3), .CW(10)
    ) u_med (
        .clk(clk), .rst(rst), .en(en), .pix_ce(pce_w[2]), .x(x_w[2]), .y(y_w[2]),
        .req_active(ra_w[2]), .hsync(hs_w[2]), .vsync(vs_w[2]), .blank_n(bn_w[2]),
        .line_start(ls_w[2]), .frame_start(fs_w[2]), .frame_cnt(fc_w[2])
    );

    function automatic int m_ht(input int i);
        return C_HA[i] + C_HFP[i] + C_HSY[i] + C_HBP[i];
    endfunction

    function automatic int m_vt(input int i);
        return C_VA[i] + C_VFP[i] + C_VSY[i] + C_VBP[i];
    endfunction

    // e = number of consecutive enabled clock edges since enable/reset.
    function automatic logic m_pix(input int i, input int e);
        return (e > 0) && (e % C_DIV[i] == 0);
    endfunction

    function automatic int m_ticks(input int i, input int e);
        return (e == 0) ? 0 : (e - 1) / C_DIV[i];
    endfunction

    function automatic logic [34:0] m_out(input int i, input int e, input int fc);
        int   ht, vt, tk, ex, ey, px, py;
        logic pce, ra, hs_a, vs_a, bn, ls, fs;
        ht   = m_ht(i);
        vt   = m_vt(i);
        pce  = m_pix(i, e);
        tk   = m_ticks(i, e);
        ex   = tk % ht;
        ey   = (tk / ht) % vt;
        ra   = (ex < C_HA[i]) && (ey < C_VA[i]);
        ls   = pce && (ex == 0);
        fs   = ls && (ey == 0);
        hs_a = 1'b0;
        vs_a = 1'b0;
        bn   = 1'b0;
        px   = 0;
        py   = 0;
        if (tk >= C_PIPE[i]) begin
            px   = (tk - C_PIPE[i]) % ht;
            py   = ((tk - C_PIPE[i]) / ht) % vt;
            hs_a = (px >= C_HA[i] + C_HFP[i]) && (px < C_HA[i] + C_HFP[i] + C_HSY[i]);
            vs_a = (py >= C_VA[i] + C_VFP[i]) && (py < C_VA[i] + C_VFP[i] + C_VSY[i]);
            bn   = (px < C_HA[i]) && (py < C_VA[i]);
        end
        return {pce, ra, (hs_a ? (C_HPOL[i] != 0) : (C_HPOL[i] == 0)),
                (vs_a ? (C_VPOL[i] != 0) : (C_VPOL[i] == 0)), bn, ls, fs,
                10'(ex), 10'(ey), 8'(fc)};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                e_m[i]  <= 0;
                fc_m[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!en) begin
                    e_m[i] <= 0;
                end else begin
                    if (m_pix(i, e_m[i]) &&
                        (m_ticks(i, e_m[i]) % (m_ht(i) * m_vt(i))) == m_ht(i) * m_vt(i) - 1)
                        fc_m[i] <= (fc_m[i] + 1) % 256;
                    e_m[i] <= e_m[i] + 1;
                end
            end
        end
    end

    task automatic test_reset();
        logic [34:0] got, exp;
        #1 rst = 1'b0;
        en = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            got = {pce_w[i], ra_w[i], hs_w[i], vs_w[i], bn_w[i], ls_w[i], fs_w[i], x_w[i], y_w[i], fc_w[i]};
            exp = {1'b0, 1'b1, (C_HPOL[i] == 0), (C_VPOL[i] == 0), 3'b000, 10'd0, 10'd0, 8'd0};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL reset_state inst=%0d got=%h expected=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_default_start();
        int ticks, low_cnt, first_low_x, prev_x, prev_y;
        logic wrapped;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pce_w[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL start_early_pix got=%b expected=0", pce_w[0]);
        end
        @(negedge clk);
        n_checks++;
        if ({pce_w[0], fs_w[0], x_w[0], y_w[0]} !== {1'b1, 1'b1, 10'd0, 10'd0}) begin
            n_errors++;
            $display("FAIL start_first_tick got pce=%b fs=%b x=%0d y=%0d expected 1 1 0 0",
                     pce_w[0], fs_w[0], x_w[0], y_w[0]);
        end
        ticks = 0; low_cnt = 0; first_low_x = -1; prev_x = 0; prev_y = 0; wrapped = 1'b0;
        for (int c = 1; c <= 2000 && !wrapped; c++) begin
            @(negedge clk);
            if (c <= 40) begin
                n_checks++;
                if (pce_w[0] !== (c % 2 == 0)) begin
                    n_errors++;
                    $display("FAIL pix_ce_duty cycle=%0d got=%b expected=%b", c, pce_w[0], (c % 2 == 0));
                end
            end
            if (pce_w[0]) begin
                ticks++;
                if (hs_w[0] === 1'b0) begin
                    low_cnt++;
                    if (first_low_x < 0) first_low_x = int'(x_w[0]);
                end
                if (x_w[0] == 10'd0 && y_w[0] == 10'd1) wrapped = 1'b1;
                else begin
                    prev_x = int'(x_w[0]);
                    prev_y = int'(y_w[0]);
                end
            end
        end
        n_checks++;
        if (!wrapped || ticks != 800 || prev_x != 799 || prev_y != 0) begin
            n_errors++;
            $display("FAIL line_wrap got wrapped=%b ticks=%0d last=(%0d,%0d) expected 1 800 (799,0)",
                     wrapped, ticks, prev_x, prev_y);
        end
        n_checks++;
        if (low_cnt != 96) begin
            n_errors++;
            $display("FAIL hsync_width got=%0d expected=96", low_cnt);
        end
        n_checks++;
        if (first_low_x != 658) begin
            n_errors++;
            $display("FAIL hsync_start_x got=%0d expected=658", first_low_x);
        end
    endtask

    task automatic test_en_drop();
        logic       found;
        logic [7:0] fc1;
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            if (pce_w[0] && x_w[0] == 10'd300) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL en_drop_reach_x300 got=timeout expected=x300");
        end
        fc1 = fc_w[1];
        en = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({pce_w[0], ls_w[0], fs_w[0], bn_w[0], hs_w[0], vs_w[0], x_w[0], y_w[0]} !==
            {6'b000011, 10'd0, 10'd0}) begin
            n_errors++;
            $display("FAIL en_drop_flush got pce=%b ls=%b fs=%b bn=%b hs=%b vs=%b x=%0d y=%0d expected 0 0 0 0 1 1 0 0",
                     pce_w[0], ls_w[0], fs_w[0], bn_w[0], hs_w[0], vs_w[0], x_w[0], y_w[0]);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (fc_w[1] !== fc1) begin
            n_errors++;
            $display("FAIL en_drop_fc_hold got=%0d expected=%0d", fc_w[1], fc1);
        end
        en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pce_w[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL en_rise_early_pix got=%b expected=0", pce_w[0]);
        end
        @(negedge clk);
        n_checks++;
        if ({pce_w[0], fs_w[0], x_w[0], y_w[0]} !== {1'b1, 1'b1, 10'd0, 10'd0}) begin
            n_errors++;
            $display("FAIL en_rise_frame_start got pce=%b fs=%b x=%0d y=%0d expected 1 1 0 0",
                     pce_w[0], fs_w[0], x_w[0], y_w[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic found;
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            if (pce_w[0] && x_w[0] == 10'd700) found = 1'b1;
        end
        n_checks++;
        if (!found || fc_w[1] == 8'd0) begin
            n_errors++;
            $display("FAIL rst_mid_setup got found=%b fc1=%0d expected found=1 fc1>0", found, fc_w[1]);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({pce_w[0], bn_w[0], hs_w[0], vs_w[0], x_w[0], y_w[0], fc_w[1]} !==
            {4'b0011, 10'd0, 10'd0, 8'd0}) begin
            n_errors++;
            $display("FAIL rst_mid_async got pce=%b bn=%b hs=%b vs=%b x=%0d y=%0d fc1=%0d expected 0 0 1 1 0 0 0",
                     pce_w[0], bn_w[0], hs_w[0], vs_w[0], x_w[0], y_w[0], fc_w[1]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({pce_w[0], fs_w[0], x_w[0], y_w[0], fc_w[0]} !== {2'b11, 10'd0, 10'd0, 8'd0}) begin
            n_errors++;
            $display("FAIL rst_mid_restart got pce=%b fs=%b x=%0d y=%0d fc=%0d expected 1 1 0 0 0",
                     pce_w[0], fs_w[0], x_w[0], y_w[0], fc_w[0]);
        end
    endtask

    task automatic test_small_frame();
        int nfs, t2, t3, bn_cnt, hs_cnt, vs_cnt;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({pce_w[1], fs_w[1]} !== 2'b11) begin
            n_errors++;
            $display("FAIL small_first_tick got pce=%b fs=%b expected 1 1", pce_w[1], fs_w[1]);
        end
        nfs = 1; t2 = 0; t3 = 0; bn_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        for (int c = 1; c <= 200 && nfs < 3; c++) begin
            @(negedge clk);
            if (fs_w[1]) begin
                nfs++;
                if (nfs == 2) t2 = c;
                if (nfs == 3) t3 = c;
            end
            if (nfs == 2) begin
                bn_cnt += int'(bn_w[1]);
                hs_cnt += int'(hs_w[1]);
                vs_cnt += int'(vs_w[1]);
            end
        end
        n_checks++;
        if (nfs != 3 || t3 - t2 != 35) begin
            n_errors++;
            $display("FAIL small_frame_period got pulses=%0d period=%0d expected 3 35", nfs, t3 - t2);
        end
        n_checks++;
        if (bn_cnt != 8) begin
            n_errors++;
            $display("FAIL small_blank_count got=%0d expected=8", bn_cnt);
        end
        n_checks++;
        if (hs_cnt != 5 || vs_cnt != 7) begin
            n_errors++;
            $display("FAIL small_sync_count got hs=%0d vs=%0d expected 5 7", hs_cnt, vs_cnt);
        end
    endtask

    task automatic test_frame_wrap();
        logic found;
        int   wait_c;
        found = 1'b0;
        for (int c = 0; c < 10000 && !found; c++) begin
            @(negedge clk);
            if (fc_w[1] == 8'd255) found = 1'b1;
        end
        wait_c = 0;
        for (int c = 1; c <= 60 && found && wait_c == 0; c++) begin
            @(negedge clk);
            if (fc_w[1] != 8'd255) wait_c = c;
        end
        n_checks++;
        if (!found || wait_c != 35 || fc_w[1] !== 8'd0) begin
            n_errors++;
            $display("FAIL frame_cnt_wrap got reached255=%b cycles=%0d fc=%0d expected 1 35 0",
                     found, wait_c, fc_w[1]);
        end
    endtask

    task automatic test_div8();
        int   cnt;
        logic found;
        found = 1'b0;
        for (int c = 0; c < 16 && !found; c++) begin
            @(negedge clk);
            if (pce_w[2]) found = 1'b1;
        end
        cnt = 0;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            cnt += int'(pce_w[2]);
            n_checks++;
            if (pce_w[2] !== (c % 8 == 0)) begin
                n_errors++;
                $display("FAIL div8_phase cycle=%0d got=%b expected=%b", c, pce_w[2], (c % 8 == 0));
            end
        end
        n_checks++;
        if (!found || cnt != 8) begin
            n_errors++;
            $display("FAIL div8_duty got found=%b count=%0d expected 1 8", found, cnt);
        end
    endtask

    task automatic test_random();
        logic [34:0] got, exp;
        int          r, off_hold, rst_hold;
        off_hold = 0;
        rst_hold = 0;
        rst = 1'b1;
        en  = 1'b1;
        for (int c = 0; c < 24000 && n_errors < 40; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                got = {pce_w[i], ra_w[i], hs_w[i], vs_w[i], bn_w[i], ls_w[i], fs_w[i], x_w[i], y_w[i], fc_w[i]};
                exp = m_out(i, e_m[i], fc_m[i]);
                n_checks++;
                if (got !== exp) begin
                    n_errors++;
                    $display("FAIL rand_model cycle=%0d inst=%0d got=%h expected=%h", c, i, got, exp);
                end
            end
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst = 1'b1;
            end else if (off_hold > 0) begin
                off_hold--;
                if (off_hold == 0) en = 1'b1;
            end else begin
                r = int'($urandom_range(0, 9999));
                if (r < 3) begin
                    en = 1'b0;
                    off_hold = int'($urandom_range(1, 6));
                end else if (r == 3) begin
                    rst = 1'b0;
                    rst_hold = int'($urandom_range(1, 3));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_start();
        test_en_drop();
        test_reset_mid();
        test_small_frame();
        test_frame_wrap();
        test_div8();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
